// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state encoding, word geometry and config record for pulse_gen_p16.
package pulse_gen_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int SAMPLES_PER_WORD = 16;
    localparam int CFG_W            = 32;
    localparam int MIN_PERIOD_DEF   = 32;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
`ifdef PULSEGEN_BURST_COUNT_EN
        logic [15:0]      count;
`endif
    } cfg_t;

    function automatic cfg_t idle_cfg(input int min_period);
        idle_cfg        = '0;
        idle_cfg.period = CFG_W'(min_period);
    endfunction

endpackage

// File: rtl/pulse_gen_p16_render.sv
// pulse_word_render: renders one 16-sample word from the current phase, handling at most one period wrap.
module pulse_word_render
    import pulse_gen_pkg::*;
(
    input  logic [CFG_W-1:0]            phase,
    input  logic [CFG_W-1:0]            act_period,
    input  logic [CFG_W-1:0]            act_high,
    input  logic [CFG_W-1:0]            nxt_high,
    output logic [SAMPLES_PER_WORD-1:0] word,
    output logic                        wrap,
    output logic [3:0]                  wrap_idx,
    output logic [CFG_W-1:0]            next_phase
);

    logic [CFG_W:0] s, sw, per, thr;

    // Per-sample compare; samples at or after the wrap restart at 0 and use the incoming high time.
    always_comb begin
        word     = '0;
        wrap     = 1'b0;
        wrap_idx = '0;
        s        = '0;
        sw       = '0;
        thr      = '0;
        per      = {1'b0, act_period};
        for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
            s = {1'b0, phase} + (CFG_W+1)'(i);
            if (!wrap && s >= per) begin
                wrap     = 1'b1;
                wrap_idx = 4'(i);
            end
            sw      = wrap ? s - per : s;
            thr     = {1'b0, wrap ? nxt_high : act_high};
            word[i] = sw < thr;
        end
        next_phase = wrap ? CFG_W'(SAMPLES_PER_WORD) - CFG_W'(wrap_idx)
                          : phase + CFG_W'(SAMPLES_PER_WORD);
    end

endmodule

// File: rtl/pulse_gen_p16.sv
// pulse_gen_p16: period/duty square-wave generator producing 16 samples per clock, config applied at period boundaries.
// Burst counting (cfg_count, burst_done) is built when PULSEGEN_BURST_COUNT_EN is defined; PW must not exceed 32.
module pulse_gen_p16
    import pulse_gen_pkg::*;
#(
    parameter int PW         = CFG_W,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_period,
    input  logic [PW-1:0] cfg_high,
    output logic          cfg_error,
    output logic [15:0]   out_p16,
    output logic          period_start,
    output logic [3:0]    start_t,
    output logic          running
`ifdef PULSEGEN_BURST_COUNT_EN
    ,
    input  logic [15:0]   cfg_count,
    output logic          burst_done
`endif
);

    state_t           state_q, state_d;
    logic [CFG_W-1:0] phase_q, phase_d, next_phase;
    cfg_t             act_q, act_d, pend_q, pend_d, nxt, offer;
    logic             ready_q, ready_d, err_q, err_d, ps_q, ps_d, run_q, run_d;
    logic [15:0]      out_q, out_d, word;
    logic [3:0]       st_q, st_d, k;
    logic             wrap, accept, bad, live, stop, take, bstop, armed;

    assign nxt    = ready_q ? act_q : pend_q;
    assign accept = cfg_valid && ready_q;
    assign bad    = offer.period < CFG_W'(MIN_PERIOD);

    pulse_word_render u_render (
        .phase     (phase_q),
        .act_period(act_q.period),
        .act_high  (act_q.high),
        .nxt_high  (nxt.high),
        .word      (word),
        .wrap      (wrap),
        .wrap_idx  (k),
        .next_phase(next_phase)
    );

    // Widen the offered fields into the config record.
    always_comb begin
        offer        = '0;
        offer.period = CFG_W'(cfg_period);
        offer.high   = CFG_W'(cfg_high);
`ifdef PULSEGEN_BURST_COUNT_EN
        offer.count  = cfg_count;
`endif
    end

    // Next state, next word and config promotion; the pending slot only moves to active at a wrap or while idle.
    always_comb begin
        state_d = state_q;
        phase_d = '0;
        act_d   = act_q;
        pend_d  = pend_q;
        ready_d = ready_q;
        out_d   = '0;
        ps_d    = 1'b0;
        st_d    = '0;
        run_d   = state_q != IDLE;
        err_d   = accept && bad;
        live    = state_q == RUN || (state_q == DRAIN && enable);
        stop    = state_q != IDLE && wrap && (!live || bstop);
        take    = state_q == IDLE || wrap;
        if (state_q == IDLE) begin
            state_d = enable && armed ? RUN : IDLE;
        end else begin
            state_d = stop ? IDLE : (enable ? RUN : DRAIN);
            phase_d = next_phase;
            out_d   = stop ? word & ((16'h1 << k) - 16'h1) : word;
            ps_d    = (wrap && !stop) || phase_q == '0;
            st_d    = wrap && !stop ? k : '0;
        end
        if (take) act_d = nxt;
        if (accept && !bad) begin
            pend_d  = offer;
            ready_d = 1'b0;
        end else if (take) begin
            ready_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            act_q   <= idle_cfg(MIN_PERIOD);
            pend_q  <= idle_cfg(MIN_PERIOD);
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            out_q   <= '0;
            ps_q    <= 1'b0;
            st_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            out_q   <= out_d;
            ps_q    <= ps_d;
            st_q    <= st_d;
            run_q   <= run_d;
        end
    end

`ifdef PULSEGEN_BURST_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        armed_q, armed_d, done_q, done_d;

    assign bstop      = act_q.count != '0 && ({1'b0, cnt_q} + 17'd1) >= {1'b0, act_q.count};
    assign armed      = armed_q;
    assign burst_done = done_q;

    // Count completed periods; after a finished burst, restart waits for enable to go low once.
    always_comb begin
        cnt_d   = state_q == IDLE ? '0 : (wrap ? cnt_q + 16'd1 : cnt_q);
        done_d  = stop && bstop;
        armed_d = !enable ? 1'b1 : (done_d ? 1'b0 : armed_q);
    end

    // Burst bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end
`else
    assign bstop = 1'b0;
    assign armed = 1'b1;
`endif

    assign cfg_ready    = ready_q;
    assign cfg_error    = err_q;
    assign out_p16      = out_q;
    assign period_start = ps_q;
    assign start_t      = st_q;
    assign running      = run_q;

endmodule

// File: tb/tb_pulse_gen_p16.sv
// tb_pulse_gen_p16: directed-vector bench for pulse_gen_p16 (burst checks when PULSEGEN_BURST_COUNT_EN is defined).
module tb_pulse_gen_p16;

    logic        clock = 1'b0;
    logic        reset, enable, cfg_valid;
    logic        cfg_ready, cfg_error, period_start, running;
    logic [31:0] cfg_period, cfg_high;
    logic [15:0] out_p16;
    logic [3:0]  start_t;
    int          vectors = 0;
    int          miscompares = 0;
    int          nps = 0;
    int          nd = 0;
`ifdef PULSEGEN_BURST_COUNT_EN
    logic [15:0] cfg_count = '0;
    logic        burst_done;
`endif

    pulse_gen_p16 dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_error   (cfg_error),
        .out_p16     (out_p16),
        .period_start(period_start),
        .start_t     (start_t),
        .running     (running)
`ifdef PULSEGEN_BURST_COUNT_EN
        ,
        .cfg_count   (cfg_count),
        .burst_done  (burst_done)
`endif
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic word(input string tag, input logic [15:0] w, input logic ps, input logic [3:0] st);
        cyc();
        chk(tag, 32'(out_p16), 32'(w));
        chk({tag, "_ps"}, 32'(period_start), 32'(ps));
        if (ps) chk({tag, "_t"}, 32'(start_t), 32'(st));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
        cyc(); cyc();
        chk("rst_out", 32'(out_p16), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_t", 32'(start_t), 0);
        chk("rst_run", 32'(running), 0);
        chk("rst_err", 32'(cfg_error), 0);
        chk("rst_rdy", 32'(cfg_ready), 1);
        reset = 1'b0;
        cfg_valid = 1'b1; cfg_period = 100; cfg_high = 50;
        cyc();
        chk("idle_rdy0", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        cyc();
        chk("idle_rdy1", 32'(cfg_ready), 1);
        enable = 1'b1;
        cyc();
        chk("lat_out", 32'(out_p16), 0);
        chk("lat_run", 32'(running), 0);
        word("w0", 16'hFFFF, 1'b1, 4'd0);
        chk("w0_run", 32'(running), 1);
        word("w1", 16'hFFFF, 1'b0, 4'd0);
        word("w2", 16'hFFFF, 1'b0, 4'd0);
        word("w3", 16'h0003, 1'b0, 4'd0);
        word("w4", 16'h0000, 1'b0, 4'd0);
        word("w5", 16'h0000, 1'b0, 4'd0);
        word("w6", 16'hFFF0, 1'b1, 4'd4);
        word("w7", 16'hFFFF, 1'b0, 4'd0);
        word("w8", 16'hFFFF, 1'b0, 4'd0);
        word("w9", 16'h003F, 1'b0, 4'd0);
        cfg_valid = 1'b1; cfg_high = 0;
        word("w10", 16'h0000, 1'b0, 4'd0);
        chk("w10_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        word("w11", 16'h0000, 1'b0, 4'd0);
        word("w12", 16'h0000, 1'b1, 4'd8);
        chk("w12_rdy", 32'(cfg_ready), 1);
        cfg_valid = 1'b1; cfg_high = 200;
        word("w13", 16'h0000, 1'b0, 4'd0);
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) word("w14_17", 16'h0000, 1'b0, 4'd0);
        word("w18", 16'hF000, 1'b1, 4'd12);
        for (int i = 0; i < 6; i++) word("w19_24", 16'hFFFF, 1'b0, 4'd0);
        word("w25", 16'hFFFF, 1'b1, 4'd0);
        cfg_valid = 1'b1; cfg_period = 20; cfg_high = 5;
        word("w26", 16'hFFFF, 1'b0, 4'd0);
        chk("bad_err", 32'(cfg_error), 1);
        chk("bad_rdy", 32'(cfg_ready), 1);
        cfg_period = 40; cfg_high = 10;
        word("w27", 16'hFFFF, 1'b0, 4'd0);
        chk("good_err", 32'(cfg_error), 0);
        chk("good_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) word("w28_30", 16'hFFFF, 1'b0, 4'd0);
        word("w31", 16'h3FFF, 1'b1, 4'd4);
        chk("w31_rdy", 32'(cfg_ready), 1);
        word("w32", 16'h0000, 1'b0, 4'd0);
        word("w33", 16'hF000, 1'b1, 4'd12);
        word("w34", 16'h003F, 1'b0, 4'd0);
        cfg_valid = 1'b1; cfg_high = 20;
        word("w35", 16'h0000, 1'b0, 4'd0);
        chk("w35_rdy", 32'(cfg_ready), 0);
        cfg_high = 30;
        word("w36", 16'hFFF0, 1'b1, 4'd4);
        chk("w36_rdy", 32'(cfg_ready), 1);
        word("w37", 16'h00FF, 1'b0, 4'd0);
        chk("w37_rdy", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        word("w38", 16'hF000, 1'b1, 4'd12);
        word("w39", 16'hFFFF, 1'b0, 4'd0);
        word("w40", 16'h03FF, 1'b0, 4'd0);
        cfg_valid = 1'b1; cfg_high = 0;
        word("w41", 16'hFFF0, 1'b1, 4'd4);
        cfg_valid = 1'b0;
        chk("w41_rdy", 32'(cfg_ready), 0);
        word("w42", 16'hFFFF, 1'b0, 4'd0);
        word("w43", 16'h0003, 1'b1, 4'd12);
        chk("w43_rdy", 32'(cfg_ready), 1);
        word("w44", 16'h0000, 1'b0, 4'd0);
        cfg_valid = 1'b1; cfg_period = 100; cfg_high = 96;
        word("w45", 16'h0000, 1'b0, 4'd0);
        cfg_valid = 1'b0;
        word("w46", 16'hFFF0, 1'b1, 4'd4);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) word("w47_51", 16'hFFFF, 1'b0, 4'd0);
        word("w52", 16'h000F, 1'b0, 4'd0);
        chk("w52_run", 32'(running), 1);
        cyc();
        chk("drained_out", 32'(out_p16), 0);
        chk("drained_run", 32'(running), 0);
        enable = 1'b1;
        cyc();
        word("r0", 16'hFFFF, 1'b1, 4'd0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) word("r1_5", 16'hFFFF, 1'b0, 4'd0);
        enable = 1'b1;
        word("r6", 16'hFFF0, 1'b1, 4'd4);
        chk("r6_run", 32'(running), 1);
        cfg_valid = 1'b1; cfg_high = 50;
        word("r7", 16'hFFFF, 1'b0, 4'd0);
        cfg_valid = 1'b0;
        chk("r7_rdy", 32'(cfg_ready), 0);
        reset = 1'b1;
        cyc();
        chk("mid_rst_out", 32'(out_p16), 0);
        chk("mid_rst_run", 32'(running), 0);
        chk("mid_rst_rdy", 32'(cfg_ready), 1);
        chk("mid_rst_ps", 32'(period_start), 0);
        reset = 1'b0;
        cyc();
        word("a0", 16'h0000, 1'b1, 4'd0);
        enable = 1'b0;
        repeat (4) cyc();
        chk("a_stop_run", 32'(running), 0);
`ifdef PULSEGEN_BURST_COUNT_EN
        cfg_valid = 1'b1; cfg_period = 32; cfg_high = 16; cfg_count = 3;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            nps += int'(period_start);
            nd += int'(burst_done);
        end
        chk("burst_ps", 32'(nps), 3);
        chk("burst_done", 32'(nd), 1);
        chk("burst_run", 32'(running), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
